// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO controller: register byte offsets and the
// width of the debounce sample divider.
package gpio_pkg;

    localparam int DEB_DIV_W = 16;

    localparam logic [4:0] GPIO_DIR_OFF    = 5'h00;
    localparam logic [4:0] GPIO_OUT_OFF    = 5'h04;
    localparam logic [4:0] GPIO_IN_OFF     = 5'h08;
    localparam logic [4:0] GPIO_RISE_OFF   = 5'h0C;
    localparam logic [4:0] GPIO_FALL_OFF   = 5'h10;
    localparam logic [4:0] GPIO_PEND_OFF   = 5'h14;
    localparam logic [4:0] GPIO_DEBEN_OFF  = 5'h18;
    localparam logic [4:0] GPIO_DEBDIV_OFF = 5'h1C;

endpackage

// File: rtl/gpio_in_filter.sv
// Single-pin input path: synchroniser chain, two-sample debounce history
// and a one-cycle delayed copy of the debounced value for edge detection.
module gpio_in_filter
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    input  logic tick_i,
    input  logic deb_en_i,
    output logic deb_o,
    output logic prev_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             hist_q, hist_d;
    logic                   deb_q, deb_d;
    logic                   prev_q;
    logic                   sync;
    logic                   deb;

    assign sync = sync_q[SYNC_STAGES-1];

    // With debounce off the history and filtered value shadow the
    // synchroniser, so enabling debounce later starts from the live level.
    always_comb begin
        hist_d = hist_q;
        deb_d  = deb_q;
        if (!deb_en_i) begin
            hist_d = {sync, sync};
            deb_d  = sync;
        end else if (tick_i) begin
            hist_d = {hist_q[0], sync};
            if (hist_d[1] == hist_d[0]) begin
                deb_d = hist_d[0];
            end
        end
    end

    // Bypass is combinational so clearing the enable acts on the next cycle.
    assign deb = deb_en_i ? deb_q : sync;

    // Synchroniser, history, filtered value and previous-cycle copy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= '0;
            deb_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            hist_q <= hist_d;
            deb_q  <= deb_d;
            prev_q <= deb;
        end
    end

    assign deb_o  = deb;
    assign prev_o = prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Register-programmed GPIO block: direction/output registers, filtered
// inputs, edge-capture interrupts with W1C pending bits and one irq line.
//
// Bus handshake: a request is a single-cycle bus_read or bus_write pulse;
// every request is acknowledged by exactly one bus_ready pulse in the next
// cycle, with bus_rdata valid only while bus_ready is high (0 otherwise).
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int                   GPIO_NUMS   = 32,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [DEB_DIV_W-1:0] DEB_DIV_RST = 16'd1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           bus_addr,
    input  logic                 bus_write,
    input  logic                 bus_read,
    input  logic [31:0]          bus_wdata,
    output logic [31:0]          bus_rdata,
    output logic                 bus_ready,
    input  logic [GPIO_NUMS-1:0] gpio_in,
    output logic [GPIO_NUMS-1:0] gpio_out,
    output logic [GPIO_NUMS-1:0] gpio_oe,
    output logic                 irq
);

    logic [GPIO_NUMS-1:0] dir_q, dir_d, out_q, out_d;
    logic [GPIO_NUMS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [GPIO_NUMS-1:0] pend_q, pend_d, deb_en_q, deb_en_d;
    logic [DEB_DIV_W-1:0] deb_div_q, deb_div_d, cnt_q, cnt_d;
    logic [31:0]          rdata_q, rdata_d, rd_val;
    logic                 ready_q, ready_d, irq_q, irq_d;
    logic [GPIO_NUMS-1:0] deb, prev, rise, fall, wdata_g;
    logic [4:0]           reg_off;
    logic                 tick;
    logic                 wr_dir, wr_out, wr_rise, wr_fall, wr_pend, wr_deben, wr_debdiv;
    logic                 unused_bus_bits;

    assign reg_off         = {bus_addr[4:2], 2'b00};
    assign wdata_g         = bus_wdata[GPIO_NUMS-1:0];
    assign unused_bus_bits = ^{bus_addr[1:0], bus_wdata};

    assign wr_dir    = bus_write && (reg_off == GPIO_DIR_OFF);
    assign wr_out    = bus_write && (reg_off == GPIO_OUT_OFF);
    assign wr_rise   = bus_write && (reg_off == GPIO_RISE_OFF);
    assign wr_fall   = bus_write && (reg_off == GPIO_FALL_OFF);
    assign wr_pend   = bus_write && (reg_off == GPIO_PEND_OFF);
    assign wr_deben  = bus_write && (reg_off == GPIO_DEBEN_OFF);
    assign wr_debdiv = bus_write && (reg_off == GPIO_DEBDIV_OFF);

    // Shared debounce prescaler tick fires when the counter reaches DEB_DIV.
    assign tick = (cnt_q == deb_div_q);

    for (genvar g = 0; g < GPIO_NUMS; g++) begin : g_pin
        gpio_in_filter #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_filter (
            .clk_i    (clk),
            .rst_i    (rst),
            .pin_i    (gpio_in[g]),
            .tick_i   (tick),
            .deb_en_i (deb_en_q[g]),
            .deb_o    (deb[g]),
            .prev_o   (prev[g])
        );
    end

    assign rise = deb & ~prev & rise_en_q;
    assign fall = ~deb & prev & fall_en_q;

    // Read mux; registers are zero-extended to the 32-bit bus.
    always_comb begin
        rd_val = '0;
        case (reg_off)
            GPIO_DIR_OFF:    rd_val[GPIO_NUMS-1:0] = dir_q;
            GPIO_OUT_OFF:    rd_val[GPIO_NUMS-1:0] = out_q;
            GPIO_IN_OFF:     rd_val[GPIO_NUMS-1:0] = deb;
            GPIO_RISE_OFF:   rd_val[GPIO_NUMS-1:0] = rise_en_q;
            GPIO_FALL_OFF:   rd_val[GPIO_NUMS-1:0] = fall_en_q;
            GPIO_PEND_OFF:   rd_val[GPIO_NUMS-1:0] = pend_q;
            GPIO_DEBEN_OFF:  rd_val[GPIO_NUMS-1:0] = deb_en_q;
            GPIO_DEBDIV_OFF: rd_val[DEB_DIV_W-1:0] = deb_div_q;
            default:         rd_val = '0;
        endcase
    end

    // Next-state for registers, prescaler, pending bits and bus response.
    always_comb begin
        dir_d     = wr_dir    ? wdata_g : dir_q;
        out_d     = wr_out    ? wdata_g : out_q;
        rise_en_d = wr_rise   ? wdata_g : rise_en_q;
        fall_en_d = wr_fall   ? wdata_g : fall_en_q;
        deb_en_d  = wr_deben  ? wdata_g : deb_en_q;
        deb_div_d = wr_debdiv ? bus_wdata[DEB_DIV_W-1:0] : deb_div_q;
        cnt_d     = tick ? '0 : cnt_q + DEB_DIV_W'(1);
        if (wr_debdiv) begin
            cnt_d = '0;
        end
        // New events are OR-ed in after the clear so a same-cycle set wins.
        pend_d  = (pend_q & ~(wr_pend ? wdata_g : '0)) | rise | fall;
        irq_d   = |pend_q;
        ready_d = bus_read | bus_write;
        rdata_d = bus_read ? rd_val : '0;
    end

    // All controller state; reset drops any acknowledge in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            deb_en_q  <= '0;
            deb_div_q <= DEB_DIV_RST;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            deb_en_q  <= deb_en_d;
            deb_div_q <= deb_div_d;
            cnt_q     <= cnt_d;
            irq_q     <= irq_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    assign gpio_oe   = dir_q;
    assign gpio_out  = out_q;
    assign irq       = irq_q;
    assign bus_ready = ready_q;
    assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: register tables plus hand-timed sequences
// for input latency, debounce filtering, W1C collision and async reset.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  bus_addr;
    logic        bus_write;
    logic        bus_read;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    gpio_ctrl #(
        .GPIO_NUMS   (32),
        .SYNC_STAGES (2),
        .DEB_DIV_RST (16'd1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_write (bus_write),
        .bus_read  (bus_read),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Driver tasks: entered at a negedge, leave at the negedge of the ack cycle.
    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_write = 1'b1;
        @(negedge clk);
        bus_write = 1'b0;
        check("wr_ack", {31'b0, bus_ready}, 32'd1);
        check("wr_rdata_zero", bus_rdata, 32'd0);
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        bus_addr = a;
        bus_read = 1'b1;
        @(negedge clk);
        bus_read = 1'b0;
        check("rd_ack", {31'b0, bus_ready}, 32'd1);
        d = bus_rdata;
    endtask

    task automatic set_vec(input int i, input logic wr, input logic [4:0] a,
                           input logic [31:0] d, input logic [31:0] e, input string n);
        vecs[i].wr   = wr;
        vecs[i].addr = a;
        vecs[i].data = d;
        vecs[i].exp  = e;
        vecs[i].name = n;
    endtask

    task automatic run_table(input int n);
        logic [31:0] rd;
        for (int i = 0; i < n; i++) begin
            if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].data);
            else begin
                bus_rd(vecs[i].addr, rd);
                check(vecs[i].name, rd, vecs[i].exp);
            end
        end
    endtask

    task automatic load_reset_table();
        set_vec(0, 1'b0, GPIO_DIR_OFF,    '0, 32'h0,    "rst_dir");
        set_vec(1, 1'b0, GPIO_OUT_OFF,    '0, 32'h0,    "rst_out");
        set_vec(2, 1'b0, GPIO_IN_OFF,     '0, 32'h0,    "rst_in");
        set_vec(3, 1'b0, GPIO_RISE_OFF,   '0, 32'h0,    "rst_rise_en");
        set_vec(4, 1'b0, GPIO_FALL_OFF,   '0, 32'h0,    "rst_fall_en");
        set_vec(5, 1'b0, GPIO_PEND_OFF,   '0, 32'h0,    "rst_pend");
        set_vec(6, 1'b0, GPIO_DEBEN_OFF,  '0, 32'h0,    "rst_deb_en");
        set_vec(7, 1'b0, GPIO_DEBDIV_OFF, '0, 32'd1000, "rst_deb_div");
    endtask

    initial begin
        logic [31:0] rd;
        rst       = 1'b1;
        bus_addr  = '0;
        bus_write = 1'b0;
        bus_read  = 1'b0;
        bus_wdata = '0;
        gpio_in   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_oe", gpio_oe, 32'd0);
        check("rst_out_pins", gpio_out, 32'd0);
        check("rst_ready", {31'b0, bus_ready}, 32'd0);

        // Reset values of every register
        load_reset_table();
        run_table(8);

        // Direction and output drive, read-back in the very next cycle
        bus_wr(GPIO_DIR_OFF, 32'h0000_00F0);
        check("oe_after_dir", gpio_oe, 32'h0000_00F0);
        bus_rd(GPIO_DIR_OFF, rd);
        check("dir_readback", rd, 32'h0000_00F0);
        bus_wr(GPIO_OUT_OFF, 32'h0000_00A5);
        check("out_after_wr", gpio_out, 32'h0000_00A5);
        check("oe_held", gpio_oe, 32'h0000_00F0);
        bus_rd(GPIO_OUT_OFF, rd);
        check("out_readback", rd, 32'h0000_00A5);

        // Register behaviour table
        set_vec(0,  1'b1, GPIO_RISE_OFF,   32'hFFFF_FFFF, '0,            "");
        set_vec(1,  1'b0, GPIO_RISE_OFF,   '0,            32'hFFFF_FFFF, "rise_en_rw");
        set_vec(2,  1'b1, GPIO_FALL_OFF,   32'h0F0F_0F0F, '0,            "");
        set_vec(3,  1'b0, GPIO_FALL_OFF,   '0,            32'h0F0F_0F0F, "fall_en_rw");
        set_vec(4,  1'b1, GPIO_IN_OFF,     32'hDEAD_BEEF, '0,            "");
        set_vec(5,  1'b0, GPIO_IN_OFF,     '0,            32'h0,         "in_ro");
        set_vec(6,  1'b1, GPIO_DEBDIV_OFF, 32'h1234_0007, '0,            "");
        set_vec(7,  1'b0, GPIO_DEBDIV_OFF, '0,            32'h0000_0007, "deb_div_16b");
        set_vec(8,  1'b1, GPIO_DEBEN_OFF,  32'h8000_0001, '0,            "");
        set_vec(9,  1'b0, GPIO_DEBEN_OFF,  '0,            32'h8000_0001, "deb_en_rw");
        set_vec(10, 1'b1, GPIO_PEND_OFF,   32'hFFFF_FFFF, '0,            "");
        set_vec(11, 1'b0, GPIO_PEND_OFF,   '0,            32'h0,         "pend_w1c_idle");
        set_vec(12, 1'b1, GPIO_DEBEN_OFF,  32'h0,         '0,            "");
        set_vec(13, 1'b1, GPIO_FALL_OFF,   32'h0,         '0,            "");
        set_vec(14, 1'b1, GPIO_RISE_OFF,   32'h1,         '0,            "");
        set_vec(15, 1'b0, GPIO_RISE_OFF,   '0,            32'h1,         "rise_en_final");
        run_table(16);

        // Undebounced rise on pin 0: IN after 2 edges, PEND +1, irq +1
        gpio_in[0] = 1'b1;
        @(negedge clk);
        bus_addr = GPIO_IN_OFF;
        bus_read = 1'b1;
        @(negedge clk);
        check("in0_after_1_edge", bus_rdata, 32'h0);
        @(negedge clk);
        bus_read = 1'b0;
        check("in0_after_2_edges", bus_rdata, 32'h1);
        check("irq_before_pend", {31'b0, irq}, 32'd0);
        @(negedge clk);
        check("irq_after_rise", {31'b0, irq}, 32'd1);
        bus_rd(GPIO_PEND_OFF, rd);
        check("pend_rise0", rd, 32'h1);

        // W1C: irq falls two cycles after the write
        bus_addr  = GPIO_PEND_OFF;
        bus_wdata = 32'h1;
        bus_write = 1'b1;
        @(negedge clk);
        bus_write = 1'b0;
        check("irq_held_at_ack", {31'b0, irq}, 32'd1);
        @(negedge clk);
        check("irq_cleared", {31'b0, irq}, 32'd0);
        bus_rd(GPIO_PEND_OFF, rd);
        check("pend_cleared", rd, 32'h0);

        // Debounced falling edge on pin 2 with DEB_DIV = 3
        bus_wr(GPIO_FALL_OFF, 32'h4);
        gpio_in[2] = 1'b1;
        repeat (4) @(negedge clk);
        bus_wr(GPIO_DEBDIV_OFF, 32'd3);
        bus_wr(GPIO_DEBEN_OFF, 32'h4);
        repeat (4) @(negedge clk);
        gpio_in[2] = 1'b0;
        repeat (3) @(negedge clk);
        gpio_in[2] = 1'b1;
        repeat (12) @(negedge clk);
        bus_rd(GPIO_PEND_OFF, rd);
        check("glitch_no_pend", rd, 32'h0);
        bus_rd(GPIO_IN_OFF, rd);
        check("glitch_in_held", rd, 32'h5);
        gpio_in[2] = 1'b0;
        repeat (14) @(negedge clk);
        bus_rd(GPIO_PEND_OFF, rd);
        check("deb_fall_pend", rd, 32'h4);
        bus_rd(GPIO_IN_OFF, rd);
        check("deb_in_low", rd, 32'h1);

        // Rise on pin 5 in the same cycle as its W1C clear: set wins
        bus_wr(GPIO_PEND_OFF, 32'hFFFF_FFFF);
        bus_rd(GPIO_PEND_OFF, rd);
        check("pend_all_cleared", rd, 32'h0);
        bus_wr(GPIO_RISE_OFF, 32'h20);
        gpio_in[5] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_addr  = GPIO_PEND_OFF;
        bus_wdata = 32'h20;
        bus_write = 1'b1;
        @(negedge clk);
        bus_write = 1'b0;
        bus_rd(GPIO_PEND_OFF, rd);
        check("set_beats_clear", rd, 32'h20);
        bus_wr(GPIO_RISE_OFF, 32'h0);
        bus_rd(GPIO_PEND_OFF, rd);
        check("pend_kept_on_en_change", rd, 32'h20);
        check("irq_from_pin5", {31'b0, irq}, 32'd1);

        // Asynchronous reset while a read acknowledge is in flight
        bus_wr(GPIO_DIR_OFF, 32'h0000_00FF);
        gpio_in  = '0;
        bus_addr = GPIO_DIR_OFF;
        bus_read = 1'b1;
        @(posedge clk);
        #2;
        bus_read = 1'b0;
        check("pre_rst_ready", {31'b0, bus_ready}, 32'd1);
        check("pre_rst_rdata", bus_rdata, 32'h0000_00FF);
        rst = 1'b1;
        #1;
        check("async_rst_ready", {31'b0, bus_ready}, 32'd0);
        check("async_rst_rdata", bus_rdata, 32'd0);
        check("async_rst_oe", gpio_oe, 32'd0);
        check("async_rst_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        load_reset_table();
        run_table(8);
        check("post_rst_out_pins", gpio_out, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised GPIO controller that replaces fixed pin pass-through and pulldown wiring at SoC top level with a register-programmed pin block. It provides per-pin direction, synchronised and optionally debounced inputs, rising/falling edge interrupt capture with write-1-to-clear pending bits, and a single aggregated interrupt line. It sits on the SoC peripheral bus beside the UART. Pad tristate and pull resolution stay in the top-level wrapper.

## Interface
Parameters:
- GPIO_NUMS, 32: number of pins, 1..32.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- DEB_DIV_RST, 16'd1000: reset value of the debounce sample divider.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous and active-high.
- bus_addr  in  5  byte offset; bits [1:0] ignored.
- bus_write  in  1  write request, single-cycle pulse.
- bus_read  in  1  read request, single-cycle pulse; never asserted together with bus_write.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, valid while bus_ready is high.
- bus_ready  out  1  one-cycle acknowledge.
- gpio_in  in  GPIO_NUMS  asynchronous pad inputs.
- gpio_out  out  GPIO_NUMS  output values.
- gpio_oe  out  GPIO_NUMS  output enables, 1 = drive.
- irq  out  1  level interrupt.

## Operation
Register map. Each register is GPIO_NUMS bits, zero-extended on read; unused bits read 0.
- 0x00 DIR, RW. 1 = output. Drives gpio_oe directly.
- 0x04 OUT, RW. Drives gpio_out directly.
- 0x08 IN, RO. Debounced input value for every pin, regardless of direction. Writes are ignored.
- 0x0C RISE_EN, RW. 0x10 FALL_EN, RW.
- 0x14 PEND, W1C. Writing 1 clears the bit; writing 0 has no effect.
- 0x18 DEB_EN, RW. Per-pin debounce enable.
- 0x1C DEB_DIV, RW, bits [15:0].
- Unmapped offsets: reads return 0, writes are ignored, bus_ready is still returned.

Input path, per pin:
- The pin passes through a SYNC_STAGES flop chain; its output is sync.
- A shared 16-bit prescaler counts 0..DEB_DIV and emits a one-cycle tick at wrap. DEB_DIV = 0 produces a tick every cycle.
- Writing DEB_DIV restarts the prescaler at 0.
- Debounce: on each tick, sample sync into a 2-entry history. The debounced value takes the sampled value when both history entries are equal.
- If DEB_EN = 0, the debounced value equals sync every cycle. Clearing DEB_EN takes effect on the next cycle.

Edge and interrupt:
- prev holds the debounced value from the previous cycle.
- rise = deb & ~prev & RISE_EN; fall = ~deb & prev & FALL_EN.
- PEND[i] is set on rise[i] | fall[i].
- irq is a register loaded with |PEND.
- If a set and a W1C clear of the same bit land in the same cycle, the set wins.
- Changing RISE_EN or FALL_EN never alters existing PEND bits.

Reset values:
- DIR, OUT, RISE_EN, FALL_EN, PEND, DEB_EN = 0.
- DEB_DIV = DEB_DIV_RST. Prescaler = 0.
- Synchroniser chain, history, debounced value and prev = 0.
- gpio_oe = 0, gpio_out = 0, irq = 0, bus_ready = 0, bus_rdata = 0.
- Reset mid-transaction drops the pending bus_ready.
- Because prev resets to 0, a pin held high through reset produces one rise event after reset if RISE_EN is set.

## Timing
- Bus read: request in cycle N; bus_ready and bus_rdata are registered and valid in cycle N+1 for exactly one cycle. bus_rdata is 0 when bus_ready is low.
- Bus write: the register updates at the end of cycle N; bus_ready is high in cycle N+1. gpio_out and gpio_oe change in cycle N+1.
- Back-to-back requests every cycle are supported, with one acknowledge per request.
- A read in the cycle after a write to the same register returns the new value.
- Input with DEB_EN = 0: a gpio_in change meeting setup before edge E is visible in IN after SYNC_STAGES edges. PEND is set one cycle later; irq rises one cycle after PEND.
- Input with DEB_EN = 1: a change is accepted after two consecutive ticks agree, i.e. about 2×(DEB_DIV+1) cycles plus synchroniser latency. Pulses shorter than one tick period are filtered.

## Structure
- Shared package gpio_pkg holds:
  - register offset constants (GPIO_DIR_OFF … GPIO_DEBDIV_OFF);
  - the DEB_DIV width constant.
- One sub-module, gpio_in_filter: synchroniser, debounce history and prev for a single pin, with tick and deb_en as inputs. Instantiate it GPIO_NUMS times in a generate loop.
- The prescaler, registers and bus logic stay in gpio_ctrl.

## Test plan
- Reset, then read every offset: all return 0 except 0x1C, which returns 1000; gpio_oe = 0, irq = 0.
- Write DIR = 0x0000_00F0, then OUT = 0x0000_00A5: gpio_oe = 0xF0 and gpio_out = 0xA5 in the cycle after each acknowledge. Read back 0xF0 and 0xA5.
- DEB_EN = 0, RISE_EN = 0x1. Drive gpio_in[0] 0→1: IN[0] = 1 after 2 cycles, PEND = 0x1 one cycle later, irq one cycle after that. Write PEND = 0x1: irq drops two cycles later.
- FALL_EN = 0x4, DEB_EN = 0x4, DEB_DIV = 3. Apply a 3-cycle low glitch on gpio_in[2] (held high beforehand): IN[2] stays 1 and there is no PEND. Then hold it low for 12 cycles: PEND[2] = 1.
- Force a rise on pin 5 in the same cycle as a W1C write of 0x20: PEND[5] remains 1.
- Assert rst during a pending read acknowledge with DIR = 0xFF: bus_ready = 0, gpio_oe = 0 and irq = 0 asynchronously; after release, reads return reset values.
